// File: rtl/ball_ctrl_if.sv
// Bus bundle between the game-logic block and its host: frame pulse, restart,
// paddle positions in; ball position, scores and match status out.
interface ball_ctrl_if #(
  parameter int X_POS_W = 10,
  parameter int Y_POS_W = 9
);
  logic               new_frame_i;
  logic               restart_i;
  logic [X_POS_W-1:0] player_paddle_x_i;
  logic [Y_POS_W-1:0] player_paddle_y_i;
  logic [X_POS_W-1:0] pc_paddle_x_i;
  logic [Y_POS_W-1:0] pc_paddle_y_i;
  logic [X_POS_W-1:0] ball_x_o;
  logic [Y_POS_W-1:0] ball_y_o;
  logic [3:0]         score_player_o;
  logic [3:0]         score_pc_o;
  logic               point_o;
  logic               game_over_o;

  // Host side: drives frame/restart/paddles, observes ball and score
  modport master (
    output new_frame_i, restart_i,
    output player_paddle_x_i, player_paddle_y_i, pc_paddle_x_i, pc_paddle_y_i,
    input  ball_x_o, ball_y_o, score_player_o, score_pc_o, point_o, game_over_o
  );

  // Game-logic side
  modport slave (
    input  new_frame_i, restart_i,
    input  player_paddle_x_i, player_paddle_y_i, pc_paddle_x_i, pc_paddle_y_i,
    output ball_x_o, ball_y_o, score_player_o, score_pc_o, point_o, game_over_o
  );
endinterface

// File: rtl/ball_ctrl.sv
// Pong ball owner: moves the ball once per frame, bounces it off walls and
// paddles, detects misses, keeps both scores and stops the match at WIN_SCORE.
// Player paddle on the left, computer paddle on the right.
module ball_ctrl #(
  parameter int SCREEN_H_RES  = 640,
  parameter int SCREEN_V_RES  = 480,
  parameter int PADDLE_WIDTH  = 8,
  parameter int PADDLE_HEIGHT = 64,
  parameter int BALL_SIDE     = 8,
  parameter int BALL_SPEED    = 2,
  parameter int SERVE_DELAY   = 60,
  parameter int WIN_SCORE     = 9,
  parameter int X_POS_W       = $clog2(SCREEN_H_RES),
  parameter int Y_POS_W       = $clog2(SCREEN_V_RES)
) (
  input  logic       clk_i,
  input  logic       rst_i,
  ball_ctrl_if.slave bus
);

  // One extra bit on the comparison paths so x - speed cannot wrap silently
  // and paddle_y + height cannot overflow.
  localparam int XW    = X_POS_W + 1;
  localparam int YW    = Y_POS_W + 1;
  localparam int CNT_W = ($clog2(SERVE_DELAY + 1) > 6) ? $clog2(SERVE_DELAY + 1) : 6;

  localparam logic [X_POS_W-1:0] CENTRE_X  = X_POS_W'((SCREEN_H_RES - BALL_SIDE) / 2);
  localparam logic [Y_POS_W-1:0] CENTRE_Y  = Y_POS_W'((SCREEN_V_RES - BALL_SIDE) / 2);
  localparam logic [XW-1:0]      SPEED_X   = XW'(BALL_SPEED);
  localparam logic [XW-1:0]      BALL_X    = XW'(BALL_SIDE);
  localparam logic [XW-1:0]      PAD_W_X   = XW'(PADDLE_WIDTH);
  localparam logic [XW-1:0]      X_MAX     = XW'(SCREEN_H_RES - BALL_SIDE);
  localparam logic [X_POS_W-1:0] BALL_XN   = X_POS_W'(BALL_SIDE);
  localparam logic [YW-1:0]      SPEED_Y   = YW'(BALL_SPEED);
  localparam logic [YW-1:0]      BALL_Y    = YW'(BALL_SIDE);
  localparam logic [YW-1:0]      PAD_H_Y   = YW'(PADDLE_HEIGHT);
  localparam logic [YW-1:0]      Y_MAX     = YW'(SCREEN_V_RES - BALL_SIDE);
  localparam logic [Y_POS_W-1:0] Y_LIMIT   = Y_POS_W'(SCREEN_V_RES - BALL_SIDE);
  localparam logic [Y_POS_W-1:0] SPEED_YN  = Y_POS_W'(BALL_SPEED);
  localparam logic [CNT_W-1:0]   SERVE_END = CNT_W'(SERVE_DELAY - 1);
  localparam logic [3:0]         WIN       = 4'(WIN_SCORE);

  typedef enum logic [1:0] {
    SERVE,
    MOVE,
    GAME_OVER
  } state_t;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [X_POS_W-1:0] x_reg, x_next;
  logic [Y_POS_W-1:0] y_reg, y_next;
  logic               dx_reg, dx_next;
  logic               dy_reg, dy_next;
  logic               point_reg, point_next;
  logic               game_over_reg, game_over_next;

  logic [XW-1:0]      x_ext, x_cand, left_edge, pc_x_ext;
  logic [YW-1:0]      y_ext, py_ext, cy_ext;
  logic               left_ovl, right_ovl;
  logic               hit_left, hit_right, miss_left, miss_right;
  logic [X_POS_W-1:0] x_move;
  logic               dx_move;
  logic [Y_POS_W-1:0] y_move;
  logic               dy_move;
  logic               move_frame;
  logic [1:0]         scored;   // [0] player scores, [1] computer scores
  logic               win;

  // Candidate motion for this frame, independent per axis
  always_comb begin
    x_ext     = {1'b0, x_reg};
    y_ext     = {1'b0, y_reg};
    py_ext    = {1'b0, bus.player_paddle_y_i};
    cy_ext    = {1'b0, bus.pc_paddle_y_i};
    pc_x_ext  = {1'b0, bus.pc_paddle_x_i};
    left_edge = {1'b0, bus.player_paddle_x_i} + PAD_W_X;
    x_cand    = dx_reg ? (x_ext + SPEED_X) : (x_ext - SPEED_X);

    left_ovl  = (y_ext + BALL_Y > py_ext) && (y_ext < py_ext + PAD_H_Y);
    right_ovl = (y_ext + BALL_Y > cy_ext) && (y_ext < cy_ext + PAD_H_Y);

    // A hit needs the ball to start on the open side of the paddle face and
    // the step to reach or cross it.
    hit_left  = !dx_reg && (x_ext >= left_edge) && (x_cand <= left_edge) && left_ovl;
    hit_right = dx_reg && (x_ext + BALL_X <= pc_x_ext) && (x_cand + BALL_X >= pc_x_ext)
                && right_ovl;
    miss_left  = !dx_reg && (x_ext < SPEED_X) && !hit_left;
    miss_right = dx_reg && (x_ext + SPEED_X > X_MAX) && !hit_right;

    x_move  = x_cand[X_POS_W-1:0];
    dx_move = dx_reg;
    if (hit_left) begin
      x_move  = left_edge[X_POS_W-1:0];
      dx_move = 1'b1;
    end else if (hit_right) begin
      x_move  = bus.pc_paddle_x_i - BALL_XN;
      dx_move = 1'b0;
    end

    y_move  = dy_reg ? (y_reg + SPEED_YN) : (y_reg - SPEED_YN);
    dy_move = dy_reg;
    if (!dy_reg && (y_ext < SPEED_Y)) begin
      y_move  = '0;
      dy_move = 1'b1;
    end else if (dy_reg && (y_ext + SPEED_Y > Y_MAX)) begin
      y_move  = Y_LIMIT;
      dy_move = 1'b0;
    end
  end

  assign move_frame = bus.new_frame_i && !bus.restart_i && (state_reg == MOVE);
  assign scored[0]  = move_frame && miss_right;
  assign scored[1]  = move_frame && miss_left;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_score
      logic [3:0] score_reg;
      logic [3:0] score_next;

      // Score for one side: cleared by restart, bumped when that side scores
      always_comb begin
        score_next = score_reg;
        if (bus.restart_i) begin
          score_next = '0;
        end else if (scored[gi]) begin
          score_next = score_reg + 4'd1;
        end
      end

      // Score register
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          score_reg <= '0;
        end else begin
          score_reg <= score_next;
        end
      end
    end
  endgenerate

  assign win = (scored[0] && (g_score[0].score_next == WIN)) ||
               (scored[1] && (g_score[1].score_next == WIN));

  // Match FSM: serve delay, per-frame motion, point handling, restart
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    x_next     = x_reg;
    y_next     = y_reg;
    dx_next    = dx_reg;
    dy_next    = dy_reg;
    point_next = 1'b0;
    if (bus.restart_i) begin
      state_next = SERVE;
      cnt_next   = '0;
      x_next     = CENTRE_X;
      y_next     = CENTRE_Y;
      dx_next    = 1'b0;
      dy_next    = 1'b0;
    end else if (bus.new_frame_i) begin
      case (state_reg)
        SERVE: begin
          if (cnt_reg == SERVE_END) begin
            cnt_next   = '0;
            state_next = MOVE;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
        MOVE: begin
          if (miss_left || miss_right) begin
            // A miss overrides any wall bounce this frame; serve toward loser
            point_next = 1'b1;
            x_next     = CENTRE_X;
            y_next     = CENTRE_Y;
            dx_next    = miss_right;
            dy_next    = !dy_reg;
            cnt_next   = '0;
            state_next = win ? GAME_OVER : SERVE;
          end else begin
            x_next  = x_move;
            dx_next = dx_move;
            y_next  = y_move;
            dy_next = dy_move;
          end
        end
        default: begin
        end
      endcase
    end
    game_over_next = (state_next == GAME_OVER);
  end

  // State and output registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg     <= SERVE;
      cnt_reg       <= '0;
      x_reg         <= CENTRE_X;
      y_reg         <= CENTRE_Y;
      dx_reg        <= 1'b0;
      dy_reg        <= 1'b0;
      point_reg     <= 1'b0;
      game_over_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      x_reg         <= x_next;
      y_reg         <= y_next;
      dx_reg        <= dx_next;
      dy_reg        <= dy_next;
      point_reg     <= point_next;
      game_over_reg <= game_over_next;
    end
  end

  assign bus.ball_x_o       = x_reg;
  assign bus.ball_y_o       = y_reg;
  assign bus.score_player_o = g_score[0].score_reg;
  assign bus.score_pc_o     = g_score[1].score_reg;
  assign bus.point_o        = point_reg;
  assign bus.game_over_o    = game_over_reg;

endmodule
